// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle RV32I main FSM and its datapath.
// The master side is the controller: it reads the IR opcode and the ALU
// branch condition and drives every strobe/select into the datapath.
// Optional macro ILLEGAL_TRAP_EN adds the illegal_instr flag.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       br_cond;
  logic       PCWrite;
  logic       PcSrc;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MtoR;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] AluOp;
  logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;

  modport master (
    input  opcode, br_cond,
    output PCWrite, PcSrc, AdrSrc, MemWrite, IRWrite, MtoR, RegWrite,
           AluSrcA, AluSrcB, AluOp, state_o, illegal_instr
  );
  modport slave (
    output opcode, br_cond,
    input  PCWrite, PcSrc, AdrSrc, MemWrite, IRWrite, MtoR, RegWrite,
           AluSrcA, AluSrcB, AluOp, state_o, illegal_instr
  );
`else
  modport master (
    input  opcode, br_cond,
    output PCWrite, PcSrc, AdrSrc, MemWrite, IRWrite, MtoR, RegWrite,
           AluSrcA, AluSrcB, AluOp, state_o
  );
  modport slave (
    output opcode, br_cond,
    input  PCWrite, PcSrc, AdrSrc, MemWrite, IRWrite, MtoR, RegWrite,
           AluSrcA, AluSrcB, AluOp, state_o
  );
`endif
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback.
// MEM_LAT (0..7) adds wait cycles to each memory access state.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky
// ILLEGAL state that raises illegal_instr until reset.
module multicycle_control #(
  parameter int MEM_LAT = 0
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    UPPER    = 4'd12
`ifdef ILLEGAL_TRAP_EN
    , ILLEGAL = 4'd13
`endif
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  // State and wait-counter register; the counter is zero on entry to every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= 3'd0;
    end else begin
      cnt <= 3'd0;
      case (state)
        FETCH: begin
          if (cnt == LAT) state <= DECODE;
          else            cnt   <= cnt + 3'd1;
        end
        DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_R:              state <= EXECR;
            OP_I:              state <= EXECI;
            OP_BR:             state <= BRANCH;
            OP_JAL:            state <= JAL;
            OP_JALR:           state <= JALR;
            OP_LUI, OP_AUIPC:  state <= UPPER;
`ifdef ILLEGAL_TRAP_EN
            default:           state <= ILLEGAL;
`else
            default:           state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD: begin
          if (cnt == LAT) state <= MEMWB;
          else            cnt   <= cnt + 3'd1;
        end
        MEMWRITE: begin
          if (cnt == LAT) state <= FETCH;
          else            cnt   <= cnt + 3'd1;
        end
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        UPPER:    state <= (bus.opcode == OP_LUI) ? FETCH : ALUWB;
`ifdef ILLEGAL_TRAP_EN
        ILLEGAL:  state <= ILLEGAL;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  // Moore output decode; everything is forced to zero while reset is held.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.PcSrc    = 1'b0;
    bus.AdrSrc   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MtoR     = 2'b00;
    bus.RegWrite = 1'b0;
    bus.AluSrcA  = 1'b0;
    bus.AluSrcB  = 2'b00;
    bus.AluOp    = 2'b00;
    bus.state_o  = 4'd0;
`ifdef ILLEGAL_TRAP_EN
    bus.illegal_instr = 1'b0;
`endif
    if (!reset) begin
      bus.state_o = state;
      case (state)
        FETCH: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = 2'b10;
          bus.IRWrite = (cnt == LAT);
          bus.PCWrite = (cnt == LAT);
        end
        DECODE: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = 2'b01;
        end
        MEMADR:   bus.AluSrcB = 2'b01;
        MEMREAD:  bus.AdrSrc  = 1'b1;
        MEMWB: begin
          bus.MtoR     = 2'b01;
          bus.RegWrite = 1'b1;
        end
        MEMWRITE: begin
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = (cnt == 3'd0);
        end
        EXECR:    bus.AluOp = 2'b10;
        EXECI: begin
          bus.AluSrcB = 2'b01;
          bus.AluOp   = 2'b10;
        end
        ALUWB:    bus.RegWrite = 1'b1;
        BRANCH: begin
          bus.AluOp   = 2'b01;
          bus.PcSrc   = 1'b1;
          bus.PCWrite = bus.br_cond;
        end
        JAL: begin
          bus.PcSrc    = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.MtoR     = 2'b10;
          bus.RegWrite = 1'b1;
        end
        JALR: begin
          bus.AluSrcB  = 2'b01;
          bus.PCWrite  = 1'b1;
          bus.MtoR     = 2'b10;
          bus.RegWrite = 1'b1;
        end
        UPPER: begin
          if (bus.opcode == OP_LUI) begin
            bus.MtoR     = 2'b11;
            bus.RegWrite = 1'b1;
          end else begin
            bus.AluSrcA = 1'b1;
            bus.AluSrcB = 2'b01;
          end
        end
`ifdef ILLEGAL_TRAP_EN
        ILLEGAL:  bus.illegal_instr = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: one instance at MEM_LAT=0
// and one at MEM_LAT=2, each checked cycle by cycle against hand-written
// state/control vectors.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst2 = 1'b1;

  multicycle_control_if if0 ();
  multicycle_control_if if2 ();

  multicycle_control #(.MEM_LAT(0)) dut0 (.clk(clk), .reset(rst0), .bus(if0));
  multicycle_control #(.MEM_LAT(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [16:0] exp_q[$];

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected {state, PCWrite, PcSrc, AdrSrc, MemWrite, IRWrite, MtoR, RegWrite, AluSrcA, AluSrcB, AluOp}.
  function automatic logic [16:0] ex(input int st, input int pcw, input int pcsrc, input int adr,
                                     input int mw, input int irw, input int mtor, input int rw,
                                     input int asa, input int asb, input int aop);
    return {4'(st), 1'(pcw), 1'(pcsrc), 1'(adr), 1'(mw), 1'(irw), 2'(mtor), 1'(rw),
            1'(asa), 2'(asb), 2'(aop)};
  endfunction

  function automatic logic [16:0] obs(input int sel);
    if (sel == 0)
      return {if0.state_o, if0.PCWrite, if0.PcSrc, if0.AdrSrc, if0.MemWrite, if0.IRWrite,
              if0.MtoR, if0.RegWrite, if0.AluSrcA, if0.AluSrcB, if0.AluOp};
    return {if2.state_o, if2.PCWrite, if2.PcSrc, if2.AdrSrc, if2.MemWrite, if2.IRWrite,
            if2.MtoR, if2.RegWrite, if2.AluSrcA, if2.AluSrcB, if2.AluOp};
  endfunction

  // Hand-computed per-state vectors.
  logic [16:0] V_FIR, V_FW, V_DEC, V_MADR, V_MRD, V_MWB, V_MWR1, V_MWRN;
  logic [16:0] V_EXR, V_EXI, V_AWB, V_BR0, V_BR1, V_JAL, V_JALR, V_LUI, V_AUI;
  initial begin
    V_FIR  = ex(0, 1,0,0,0,1, 0,0, 1,2,0);
    V_FW   = ex(0, 0,0,0,0,0, 0,0, 1,2,0);
    V_DEC  = ex(1, 0,0,0,0,0, 0,0, 1,1,0);
    V_MADR = ex(2, 0,0,0,0,0, 0,0, 0,1,0);
    V_MRD  = ex(3, 0,0,1,0,0, 0,0, 0,0,0);
    V_MWB  = ex(4, 0,0,0,0,0, 1,1, 0,0,0);
    V_MWR1 = ex(5, 0,0,1,1,0, 0,0, 0,0,0);
    V_MWRN = ex(5, 0,0,1,0,0, 0,0, 0,0,0);
    V_EXR  = ex(6, 0,0,0,0,0, 0,0, 0,0,2);
    V_EXI  = ex(7, 0,0,0,0,0, 0,0, 0,1,2);
    V_AWB  = ex(8, 0,0,0,0,0, 0,1, 0,0,0);
    V_BR0  = ex(9, 0,1,0,0,0, 0,0, 0,0,1);
    V_BR1  = ex(9, 1,1,0,0,0, 0,0, 0,0,1);
    V_JAL  = ex(10,1,1,0,0,0, 2,1, 0,0,0);
    V_JALR = ex(11,1,0,0,0,0, 2,1, 0,1,0);
    V_LUI  = ex(12,0,0,0,0,0, 3,1, 0,0,0);
    V_AUI  = ex(12,0,0,0,0,0, 0,0, 1,1,0);
  end

  // Hold one instance in reset for two edges with the given instruction inputs.
  task automatic start(input int sel, input logic [6:0] op, input logic br);
    @(negedge clk);
    if (sel == 0) begin rst0 = 1'b1; if0.opcode = op; if0.br_cond = br; end
    else          begin rst2 = 1'b1; if2.opcode = op; if2.br_cond = br; end
    #1 check($sformatf("reset_outputs_%0d", sel), 32'(obs(sel)), 32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Release reset and compare each following cycle against exp_q.
  task automatic run_seq(input int sel, input string tag);
    if (sel == 0) rst0 = 1'b0; else rst2 = 1'b0;
    #1 check($sformatf("%s[0]", tag), 32'(obs(sel)), 32'(exp_q[0]));
    for (int i = 1; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(obs(sel)), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    if0.opcode = 7'd0; if0.br_cond = 1'b0;
    if2.opcode = 7'd0; if2.br_cond = 1'b0;
    #1;

    start(0, 7'b0110011, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_EXR, V_AWB, V_FIR};
    run_seq(0, "rtype");

    start(2, 7'b0000011, 1'b0);
    exp_q = '{V_FW, V_FW, V_FIR, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MWB, V_FW};
    run_seq(2, "load_lat2");

    start(2, 7'b0100011, 1'b0);
    exp_q = '{V_FW, V_FW, V_FIR, V_DEC, V_MADR, V_MWR1, V_MWRN, V_MWRN, V_FW};
    run_seq(2, "store_lat2");

    start(2, 7'b0010011, 1'b0);
    exp_q = '{V_FW, V_FW, V_FIR, V_DEC, V_EXI, V_AWB, V_FW};
    run_seq(2, "itype_lat2");

    start(0, 7'b1100011, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_BR0, V_FIR};
    run_seq(0, "branch_nt");

    start(0, 7'b1100011, 1'b1);
    exp_q = '{V_FIR, V_DEC, V_BR1, V_FIR};
    run_seq(0, "branch_t");

    start(0, 7'b1101111, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_JAL, V_FIR};
    run_seq(0, "jal");

    start(0, 7'b1100111, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_JALR, V_FIR};
    run_seq(0, "jalr");

    start(0, 7'b0110111, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_LUI, V_FIR};
    run_seq(0, "lui");

    start(0, 7'b0010111, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_AUI, V_AWB, V_FIR};
    run_seq(0, "auipc");

    // Reset during EXECR: no ALUWB write, restart in FETCH.
    start(0, 7'b0110011, 1'b0);
    exp_q = '{V_FIR, V_DEC, V_EXR};
    run_seq(0, "rst_mid");
    rst0 = 1'b1;
    #1 check("rst_mid_held", 32'(obs(0)), 32'h0);
    @(negedge clk);
    check("rst_mid_no_write", 32'(obs(0)), 32'h0);
    rst0 = 1'b0;
    #1 check("rst_mid_fetch", 32'(obs(0)), 32'(V_FIR));
    @(negedge clk);
    check("rst_mid_decode", 32'(obs(0)), 32'(V_DEC));

    start(0, 7'b1111111, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    exp_q = '{V_FIR, V_DEC, ex(13,0,0,0,0,0,0,0,0,0,0), ex(13,0,0,0,0,0,0,0,0,0,0),
              ex(13,0,0,0,0,0,0,0,0,0,0)};
    run_seq(0, "illegal_trap");
    check("illegal_flag", 32'(if0.illegal_instr), 32'd1);
    @(negedge clk);
    rst0 = 1'b1;
    #1 check("illegal_flag_reset", 32'(if0.illegal_instr), 32'd0);
`else
    exp_q = '{V_FIR, V_DEC, V_FIR, V_DEC, V_FIR};
    run_seq(0, "unknown_nop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
